fetch_queue: RTL and testbench

- Decoupling buffer between the instruction-fetch front end and Back_End_With_Decode.
- Accepts two-instruction fetch packs, each with its PC, per-slot valids and branch-prediction pack.
- Stores them in a circular FIFO and presents them to the backend's io_i_fetch_pack_* inputs with a valid/ready handshake.
- A backend redirect (branch mispredict, mret, interrupt) flushes all buffered packs.

---
 rtl/fetch_pkg.sv | 37 +++
 rtl/fetch_queue_ram.sv | 25 ++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-pack types and widths used by the fetch front end, the queue and the backend.
// Combinational definitions only; no latency or backpressure.
package fetch_pkg;

  localparam int XLEN        = 64;
  localparam int FETCH_WIDTH = 2;
  localparam int BR_TYPE_W   = 4;
  localparam int INST_W      = 32;

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE = 4'd0,
    BR_COND = 4'd1,
    BR_JAL  = 4'd2,
    BR_JALR = 4'd3,
    BR_CALL = 4'd4,
    BR_RET  = 4'd5
  } br_type_e;

  typedef struct packed {
    logic                 bp_valid;
    logic [XLEN-1:0]      bp_target;
    logic [BR_TYPE_W-1:0] bp_branch_type;
    logic                 bp_select;
    logic                 bp_taken;
  } bp_pack_t;

  // Slot 1 sits in the upper half of insts/valids.
  typedef struct packed {
    logic [XLEN-1:0]                    pc;
    logic [FETCH_WIDTH-1:0][INST_W-1:0] insts;
    logic [FETCH_WIDTH-1:0]             valids;
    bp_pack_t                           bp;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x fetch_entry_t register array: one synchronous write port, one asynchronous read port.
// Write visible on the read port after the writing edge; no backpressure.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_dat,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_dat
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch-pack FIFO between front end and backend; enqueue-to-visible latency one edge, no bypass.
// in_ready depends only on occupancy (no full pass-through); flush clears everything and wins over both ports.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = fetch_pkg::XLEN,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 io_i_flush,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [XLEN-1:0]      io_in_pc,
  input  logic [31:0]          io_in_insts_0,
  input  logic [31:0]          io_in_insts_1,
  input  logic                 io_in_valids_0,
  input  logic                 io_in_valids_1,
  input  logic                 io_in_bp_valid,
  input  logic [XLEN-1:0]      io_in_bp_target,
  input  logic [BR_TYPE_W-1:0] io_in_bp_branch_type,
  input  logic                 io_in_bp_select,
  input  logic                 io_in_bp_taken,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [XLEN-1:0]      io_out_pc,
  output logic [31:0]          io_out_insts_0,
  output logic [31:0]          io_out_insts_1,
  output logic                 io_out_valids_0,
  output logic                 io_out_valids_1,
  output logic                 io_out_bp_valid,
  output logic [XLEN-1:0]      io_out_bp_target,
  output logic [BR_TYPE_W-1:0] io_out_bp_branch_type,
  output logic                 io_out_bp_select,
  output logic                 io_out_bp_taken,
  output logic [CW-1:0]        io_count
);

  logic [AW-1:0] head_ptr, tail_ptr;
  logic [CW-1:0] count;
  logic          enq_fire, wr_en, deq_fire;
  fetch_entry_t  wr_dat, rd_dat;

  assign io_in_ready  = (count != CW'(DEPTH));
  assign io_out_valid = (count != '0);
  assign io_count     = count;

  assign enq_fire = io_in_valid && io_in_ready && !io_i_flush;
  // A pack with both slots empty completes the handshake but carries nothing worth storing.
  assign wr_en    = enq_fire && (io_in_valids_0 || io_in_valids_1);
  assign deq_fire = io_out_valid && io_out_ready && !io_i_flush;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (io_i_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (wr_en)    tail_ptr <= tail_ptr + 1'b1;
      if (deq_fire) head_ptr <= head_ptr + 1'b1;
      case ({wr_en, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    wr_dat                   = '0;
    wr_dat.pc                = io_in_pc;
    wr_dat.insts[0]          = io_in_insts_0;
    wr_dat.insts[1]          = io_in_insts_1;
    wr_dat.valids[0]         = io_in_valids_0;
    wr_dat.valids[1]         = io_in_valids_1;
    wr_dat.bp.bp_valid       = io_in_bp_valid;
    wr_dat.bp.bp_target      = io_in_bp_target;
    wr_dat.bp.bp_branch_type = io_in_bp_branch_type;
    wr_dat.bp.bp_select      = io_in_bp_select;
    wr_dat.bp.bp_taken       = io_in_bp_taken;
  end

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (tail_ptr),
    .wr_dat  (wr_dat),
    .rd_addr (head_ptr),
    .rd_dat  (rd_dat)
  );

  assign io_out_pc             = rd_dat.pc;
  assign io_out_insts_0        = rd_dat.insts[0];
  assign io_out_insts_1        = rd_dat.insts[1];
  assign io_out_valids_0       = rd_dat.valids[0];
  assign io_out_valids_1       = rd_dat.valids[1];
  assign io_out_bp_valid       = rd_dat.bp.bp_valid;
  assign io_out_bp_target      = rd_dat.bp.bp_target;
  assign io_out_bp_branch_type = rd_dat.bp.bp_branch_type;
  assign io_out_bp_select      = rd_dat.bp.bp_select;
  assign io_out_bp_taken       = rd_dat.bp.bp_taken;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the buffer.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        io_i_flush = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [63:0] io_out_pc, io_out_bp_target;
  logic [31:0] io_out_insts_0, io_out_insts_1;
  logic        io_out_valids_0, io_out_valids_1, io_out_bp_valid, io_out_bp_select, io_out_bp_taken;
  logic [3:0]  io_out_bp_branch_type;
  logic [3:0]  io_count;

  fetch_entry_t drv = '0;
  fetch_entry_t got;
  fetch_entry_t mq[$];

  int  checks = 0;
  int  errors = 0;
  bit  check_en = 1'b0;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(64)) dut (
    .clock                 (clock),
    .resetn                (resetn),
    .io_i_flush            (io_i_flush),
    .io_in_valid           (io_in_valid),
    .io_in_ready           (io_in_ready),
    .io_in_pc              (drv.pc),
    .io_in_insts_0         (drv.insts[0]),
    .io_in_insts_1         (drv.insts[1]),
    .io_in_valids_0        (drv.valids[0]),
    .io_in_valids_1        (drv.valids[1]),
    .io_in_bp_valid        (drv.bp.bp_valid),
    .io_in_bp_target       (drv.bp.bp_target),
    .io_in_bp_branch_type  (drv.bp.bp_branch_type),
    .io_in_bp_select       (drv.bp.bp_select),
    .io_in_bp_taken        (drv.bp.bp_taken),
    .io_out_valid          (io_out_valid),
    .io_out_ready          (io_out_ready),
    .io_out_pc             (io_out_pc),
    .io_out_insts_0        (io_out_insts_0),
    .io_out_insts_1        (io_out_insts_1),
    .io_out_valids_0       (io_out_valids_0),
    .io_out_valids_1       (io_out_valids_1),
    .io_out_bp_valid       (io_out_bp_valid),
    .io_out_bp_target      (io_out_bp_target),
    .io_out_bp_branch_type (io_out_bp_branch_type),
    .io_out_bp_select      (io_out_bp_select),
    .io_out_bp_taken       (io_out_bp_taken),
    .io_count              (io_count)
  );

  assign got = {io_out_pc, io_out_insts_1, io_out_insts_0, io_out_valids_1, io_out_valids_0,
                io_out_bp_valid, io_out_bp_target, io_out_bp_branch_type, io_out_bp_select,
                io_out_bp_taken};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: the buffer is a list of packs; flush empties it, reset empties it asynchronously.
  always @(posedge clock) begin
    if (resetn) begin
      if (io_i_flush) begin
        mq.delete();
      end else begin
        bit can_take, take_out;
        can_take = (mq.size() != DEPTH);
        take_out = (mq.size() != 0) && io_out_ready;
        if (take_out) void'(mq.pop_front());
        if (io_in_valid && can_take && (drv.valids != 2'b00)) mq.push_back(drv);
      end
    end
  end

  always @(negedge resetn) mq.delete();

  always @(negedge clock) begin
    if (check_en) begin
      chk("in_ready",  256'(io_in_ready),  256'(mq.size() != DEPTH));
      chk("out_valid", 256'(io_out_valid), 256'(mq.size() != 0));
      chk("count",     256'(io_count),     256'(mq.size()));
      if (mq.size() != 0) chk("head_pack", 256'(got), 256'(mq[0]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic fetch_entry_t mk_pack(input logic [63:0] pc, input logic [31:0] i0,
                                           input logic [31:0] i1, input logic [1:0] v);
    fetch_entry_t p;
    p                   = '0;
    p.pc                = pc;
    p.insts[0]          = i0;
    p.insts[1]          = i1;
    p.valids            = v;
    p.bp.bp_valid       = pc[2];
    p.bp.bp_target      = pc + 64'h40;
    p.bp.bp_branch_type = BR_COND;
    p.bp.bp_select      = pc[3];
    p.bp.bp_taken       = pc[4];
    return p;
  endfunction

  function automatic fetch_entry_t rnd_pack();
    fetch_entry_t p;
    p                   = '0;
    p.pc                = {$urandom, $urandom};
    p.insts[0]          = $urandom;
    p.insts[1]          = $urandom;
    p.valids            = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
    p.bp.bp_valid       = 1'($urandom);
    p.bp.bp_target      = {$urandom, $urandom};
    p.bp.bp_branch_type = 4'($urandom);
    p.bp.bp_select      = 1'($urandom);
    p.bp.bp_taken       = 1'($urandom);
    return p;
  endfunction

  initial begin
    logic [63:0] exp_pc [7];
    exp_pc = '{64'h8, 64'hC, 64'h10, 64'h14, 64'h18, 64'h1C, 64'h20};

    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    @(negedge clock);
    chk("rst_out_valid", 256'(io_out_valid), 256'(0));
    chk("rst_count",     256'(io_count),     256'(0));
    chk("rst_in_ready",  256'(io_in_ready),  256'(1));
    check_en = 1'b1;

    // single pack, one-edge latency
    tick();
    drv = mk_pack(64'h4, 32'h00508093, 32'h0030a2a3, 2'b11);
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("t1_out_valid", 256'(io_out_valid),   256'(1));
    chk("t1_pc",        256'(io_out_pc),      256'(64'h4));
    chk("t1_inst0",     256'(io_out_insts_0), 256'(32'h00508093));
    chk("t1_inst1",     256'(io_out_insts_1), 256'(32'h0030a2a3));
    chk("t1_count",     256'(io_count),       256'(1));
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;

    // fill to DEPTH with output stalled
    for (int i = 0; i < DEPTH; i++) begin
      drv = mk_pack(64'(i * 4), 32'(i), 32'(i + 100), 2'b11);
      io_in_valid = 1'b1;
      tick();
    end
    drv = mk_pack(64'h20, 32'h20, 32'h120, 2'b11);
    @(negedge clock);
    chk("full_in_ready", 256'(io_in_ready), 256'(0));
    chk("full_count",    256'(io_count),    256'(8));
    tick();
    @(negedge clock);
    chk("full_hold_count", 256'(io_count),  256'(8));
    chk("full_head_pc",    256'(io_out_pc), 256'(64'h0));
    io_out_ready = 1'b1;
    tick();
    @(negedge clock);
    chk("full_deq_ready", 256'(io_in_ready), 256'(1));
    chk("full_deq_count", 256'(io_count),    256'(7));
    chk("full_deq_pc",    256'(io_out_pc),   256'(64'h4));
    tick();
    io_in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      chk("drain_order", 256'(io_out_pc), 256'(exp_pc[i]));
      tick();
    end
    io_out_ready = 1'b0;

    // flush with concurrent enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drv = mk_pack(64'h100 + 64'(i * 4), 32'h1, 32'h2, 2'b11);
      io_in_valid = 1'b1;
      tick();
    end
    drv = mk_pack(64'hF00, 32'h3, 32'h4, 2'b11);
    io_out_ready = 1'b1;
    io_i_flush = 1'b1;
    @(negedge clock);
    chk("pre_flush_count", 256'(io_count), 256'(3));
    tick();
    io_i_flush = 1'b0;
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("flush_count", 256'(io_count),     256'(0));
    chk("flush_valid", 256'(io_out_valid), 256'(0));
    repeat (3) tick();
    @(negedge clock);
    chk("flush_dropped", 256'(io_out_valid), 256'(0));
    io_out_ready = 1'b0;

    // empty-slot pack is accepted but never stored
    drv = mk_pack(64'h200, 32'h5, 32'h6, 2'b11);
    io_in_valid = 1'b1;
    tick();
    drv = mk_pack(64'h300, 32'h7, 32'h8, 2'b00);
    @(negedge clock);
    chk("v00_in_ready", 256'(io_in_ready), 256'(1));
    tick();
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("v00_count", 256'(io_count),  256'(1));
    chk("v00_head",  256'(io_out_pc), 256'(64'h200));
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    @(negedge clock);
    chk("v00_absent", 256'(io_out_valid), 256'(0));

    // asynchronous reset with occupancy 5
    tick();
    for (int i = 0; i < 5; i++) begin
      drv = mk_pack(64'h400 + 64'(i * 4), 32'h9, 32'ha, 2'b11);
      io_in_valid = 1'b1;
      tick();
    end
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("pre_rst_count", 256'(io_count), 256'(5));
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 256'(io_out_valid), 256'(0));
    chk("arst_count", 256'(io_count),     256'(0));
    #1 resetn = 1'b1;
    tick();
    drv = mk_pack(64'h500, 32'hb, 32'hc, 2'b01);
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_pc",     256'(io_out_pc),       256'(64'h500));
    chk("post_rst_v1",     256'(io_out_valids_1), 256'(0));
    chk("post_rst_count",  256'(io_count),        256'(1));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      drv          = rnd_pack();
      io_in_valid  = ($urandom_range(0, 3) != 0);
      io_out_ready = ($urandom_range(0, 2) != 0) ? (c[9] | c[8]) : 1'($urandom);
      io_i_flush   = ($urandom_range(0, 39) == 0);
    end
    tick();
    io_in_valid  = 1'b0;
    io_i_flush   = 1'b0;
    io_out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    @(negedge clock);
    chk("final_empty", 256'(io_out_valid), 256'(0));

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
